// File: rtl/mfp_seven_segment_scanner_pkg.sv
// Shared 7-segment configuration: hex word width, segment bit order,
// active-high gfedcba glyph codes and the scanner state encoding.
package mfp_seven_segment_scanner_pkg;

  localparam int MFP_7_SEGMENT_HEX_WIDTH = 32;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_CODE_0 = 7'h3F;
  localparam logic [6:0] SEG_CODE_1 = 7'h06;
  localparam logic [6:0] SEG_CODE_2 = 7'h5B;
  localparam logic [6:0] SEG_CODE_3 = 7'h4F;
  localparam logic [6:0] SEG_CODE_4 = 7'h66;
  localparam logic [6:0] SEG_CODE_5 = 7'h6D;
  localparam logic [6:0] SEG_CODE_6 = 7'h7D;
  localparam logic [6:0] SEG_CODE_7 = 7'h07;
  localparam logic [6:0] SEG_CODE_8 = 7'h7F;
  localparam logic [6:0] SEG_CODE_9 = 7'h6F;
  localparam logic [6:0] SEG_CODE_A = 7'h77;
  localparam logic [6:0] SEG_CODE_B = 7'h7C;
  localparam logic [6:0] SEG_CODE_C = 7'h39;
  localparam logic [6:0] SEG_CODE_D = 7'h5E;
  localparam logic [6:0] SEG_CODE_E = 7'h79;
  localparam logic [6:0] SEG_CODE_F = 7'h71;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/mfp_seven_segment_scanner_hex.sv
// Combinational nibble to active-high gfedcba decoder; polarity is applied
// by the caller.
module mfp_hex_to_seven_segment
  import mfp_seven_segment_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    case (hex)
      4'h0: seg = SEG_CODE_0;
      4'h1: seg = SEG_CODE_1;
      4'h2: seg = SEG_CODE_2;
      4'h3: seg = SEG_CODE_3;
      4'h4: seg = SEG_CODE_4;
      4'h5: seg = SEG_CODE_5;
      4'h6: seg = SEG_CODE_6;
      4'h7: seg = SEG_CODE_7;
      4'h8: seg = SEG_CODE_8;
      4'h9: seg = SEG_CODE_9;
      4'hA: seg = SEG_CODE_A;
      4'hB: seg = SEG_CODE_B;
      4'hC: seg = SEG_CODE_C;
      4'hD: seg = SEG_CODE_D;
      4'hE: seg = SEG_CODE_E;
      4'hF: seg = SEG_CODE_F;
      default: seg = '0;
    endcase
  end

endmodule

// File: rtl/mfp_seven_segment_scanner.sv
// Time-multiplexed common-anode 7-segment scanner: latches a whole frame at
// frame boundaries and blanks all anodes at the start of every digit slot.
module mfp_seven_segment_scanner
  import mfp_seven_segment_scanner_pkg::*;
#(
  parameter int N_DIGITS         = 8,
  parameter int SCAN_DIV_W       = 16,
  parameter int BLANK_CYCLES     = 4,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [4*N_DIGITS-1:0]   hex_value,
  input  logic [N_DIGITS-1:0]     digit_enable,
  input  logic [N_DIGITS-1:0]     dot,
  output logic [N_DIGITS-1:0]     anodes,
  output logic [6:0]              segments,
  output logic                    dp
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [SCAN_DIV_W-1:0] BLANK_LAST = SCAN_DIV_W'(BLANK_CYCLES - 1);
  localparam logic [N_DIGITS-1:0]   ANODE_OFF  = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF     = (SEG_ACTIVE_LOW != 0);

  logic [SCAN_DIV_W-1:0]        divider;
  logic [IDX_W-1:0]             index;
  logic                         tick;
  logic                         first_flag;
  logic                         frame_load;
  logic [N_DIGITS-1:0][3:0]     frame_hex;
  logic [N_DIGITS-1:0]          frame_en;
  logic [N_DIGITS-1:0]          frame_dot;

  scan_state_t                  state, state_nxt;
  logic [SCAN_DIV_W-1:0]        blank_cnt, blank_cnt_nxt;

  logic [6:0]                   seg_raw;
  logic [6:0]                   seg_pol;
  logic                         dp_pol;
  logic [N_DIGITS-1:0]          anode_on;

  assign tick       = &divider;
  assign frame_load = first_flag || (tick && (index == IDX_LAST));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      divider <= '0;
      index   <= '0;
    end else begin
      divider <= divider + 1'b1;
      if (tick) index <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end
  end

  // Whole frame captured at once so a CPU write never splits a scan.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      first_flag <= 1'b1;
      frame_hex  <= '0;
      frame_en   <= '0;
      frame_dot  <= '0;
    end else begin
      first_flag <= 1'b0;
      if (frame_load) begin
        frame_hex <= hex_value;
        frame_en  <= digit_enable;
        frame_dot <= dot;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_BLANK;
      blank_cnt <= '0;
    end else begin
      state     <= state_nxt;
      blank_cnt <= blank_cnt_nxt;
    end
  end

  // Slot tick wins over the blank-to-drive step.
  always_comb begin
    state_nxt     = state;
    blank_cnt_nxt = blank_cnt;
    if (tick) begin
      state_nxt     = ST_BLANK;
      blank_cnt_nxt = '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (blank_cnt == BLANK_LAST) state_nxt = ST_DRIVE;
          else                         blank_cnt_nxt = blank_cnt + 1'b1;
        end
        ST_DRIVE: state_nxt = ST_DRIVE;
        default:  state_nxt = ST_BLANK;
      endcase
    end
  end

  mfp_hex_to_seven_segment u_dec (
    .hex (frame_hex[index]),
    .seg (seg_raw)
  );

  always_comb begin
    anode_on        = '0;
    anode_on[index] = 1'b1;
    if (ANODE_ACTIVE_LOW != 0) anode_on = ~anode_on;
    seg_pol = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    dp_pol  = (SEG_ACTIVE_LOW != 0) ? ~frame_dot[index] : frame_dot[index];
  end

  // Segments settle during the blank window and are frozen while lit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      anodes   <= ANODE_OFF;
      segments <= SEG_OFF;
      dp       <= DP_OFF;
    end else if (state == ST_BLANK) begin
      anodes   <= ANODE_OFF;
      segments <= seg_pol;
      dp       <= dp_pol;
    end else begin
      anodes   <= frame_en[index] ? anode_on : ANODE_OFF;
    end
  end

endmodule
